// File: rtl/score_bcd_tracker_if.sv
// Score display bus: binary score and clear request in, packed-BCD and best-score status out.
interface score_bcd_tracker_if #(
    parameter int W      = 32,
    parameter int DIGITS = 8
);
    logic [W-1:0]          score;
    logic                  clear_best;
    logic [4*DIGITS-1:0]   bcd_cur;
    logic [4*DIGITS-1:0]   bcd_best;
    logic [W-1:0]          best_score;
    logic                  busy;
    logic                  done;
    logic                  new_best;

    modport master (
        output score, clear_best,
        input  bcd_cur, bcd_best, best_score, busy, done, new_best
    );

    modport slave (
        input  score, clear_best,
        output bcd_cur, bcd_best, best_score, busy, done, new_best
    );
endinterface

// File: rtl/score_bcd_tracker.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that also
// tracks the best score seen and flags when it is beaten.
module score_bcd_tracker #(
    parameter int W      = 32,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    score_bcd_tracker_if.slave  bus
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    // One double-dabble step: correct every digit >= 5, then shift in the next binary bit.
    function automatic logic [4*DIGITS-1:0] dabble_step(input logic [4*DIGITS-1:0] acc,
                                                        input logic               bit_in);
        logic [4*DIGITS-1:0] adj;
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        return {adj[4*DIGITS-2:0], bit_in};
    endfunction

    function automatic logic [4*DIGITS-1:0] saturate(input logic [W-1:0]        val,
                                                     input logic [4*DIGITS-1:0] acc);
        if (64'(val) > MAX_VAL) return {DIGITS{4'h9}};
        return acc;
    endfunction

    state_t                state_q,    state_d;
    logic [W-1:0]          last_q,     last_d;
    logic [W-1:0]          shift_q,    shift_d;
    logic [4*DIGITS-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [4*DIGITS-1:0]   cur_q,      cur_d;
    logic [4*DIGITS-1:0]   bbcd_q,     bbcd_d;
    logic [W-1:0]          best_q,     best_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  newb_q,     newb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cur_q   <= '0;
            bbcd_q  <= '0;
            best_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            newb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            bbcd_q  <= bbcd_d;
            best_q  <= best_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            newb_q  <= newb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        bbcd_d  = bbcd_q;
        best_d  = best_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        newb_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.score != last_q) begin
                    last_d  = bus.score;
                    shift_d = bus.score;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = dabble_step(acc_q, shift_q[W-1]);
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
            end
            DONE: begin
                cur_d   = saturate(last_q, acc_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (last_q > best_q) begin
                    best_d = last_q;
                    bbcd_d = cur_d;
                    newb_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear on the completing edge overrides any best-score update from it.
        if (bus.clear_best) begin
            best_d = '0;
            bbcd_d = '0;
            newb_d = 1'b0;
        end
    end

    assign bus.bcd_cur    = cur_q;
    assign bus.bcd_best   = bbcd_q;
    assign bus.best_score = best_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.new_best   = newb_q;

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Directed bench for score_bcd_tracker: conversion, latency, best tracking, saturation, clear and reset.
module tb_score_bcd_tracker;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    score_bcd_tracker_if #(.W(32), .DIGITS(8)) bus ();

    score_bcd_tracker #(.W(32), .DIGITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for done, counting busy cycles seen on the way; samples on falling edges.
    task automatic wait_done(output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        bus.score = '0;
        bus.clear_best = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_idle busy/done active cycles=%0d exp 0", pulses); end
        checks++; if (bus.bcd_cur !== 32'h0) begin errors++; $display("FAIL reset_bcd_cur got %h exp 00000000", bus.bcd_cur); end
        checks++; if (bus.bcd_best !== 32'h0) begin errors++; $display("FAIL reset_bcd_best got %h exp 00000000", bus.bcd_best); end
        checks++; if (bus.best_score !== 32'd0) begin errors++; $display("FAIL reset_best_score got %0d exp 0", bus.best_score); end
        checks++; if (bus.new_best !== 1'b0) begin errors++; $display("FAIL reset_new_best got %b exp 0", bus.new_best); end
    endtask

    task automatic test_basic();
        int cyc; bit to;
        bus.score = 32'd2048;
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 33", cyc); end
        checks++; if (bus.bcd_cur !== 32'h00002048) begin errors++; $display("FAIL basic_bcd_cur got %h exp 00002048", bus.bcd_cur); end
        checks++; if (bus.bcd_best !== 32'h00002048) begin errors++; $display("FAIL basic_bcd_best got %h exp 00002048", bus.bcd_best); end
        checks++; if (bus.best_score !== 32'd2048) begin errors++; $display("FAIL basic_best_score got %0d exp 2048", bus.best_score); end
        checks++; if (bus.new_best !== 1'b1) begin errors++; $display("FAIL basic_new_best got %b exp 1", bus.new_best); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.new_best !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got done=%b new_best=%b exp 0 0", bus.done, bus.new_best); end
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_settled_idle busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_lower_and_equal();
        int cyc; bit to;
        bus.score = 32'd1024;
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lower_timeout got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h00001024) begin errors++; $display("FAIL lower_bcd_cur got %h exp 00001024", bus.bcd_cur); end
        checks++; if (bus.bcd_best !== 32'h00002048) begin errors++; $display("FAIL lower_bcd_best got %h exp 00002048", bus.bcd_best); end
        checks++; if (bus.new_best !== 1'b0) begin errors++; $display("FAIL lower_new_best got %b exp 0", bus.new_best); end
        bus.score = 32'd2048;
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL equal_timeout got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h00002048) begin errors++; $display("FAIL equal_bcd_cur got %h exp 00002048", bus.bcd_cur); end
        checks++; if (bus.new_best !== 1'b0) begin errors++; $display("FAIL equal_new_best got %b exp 0", bus.new_best); end
        checks++; if (bus.best_score !== 32'd2048) begin errors++; $display("FAIL equal_best_score got %0d exp 2048", bus.best_score); end
    endtask

    task automatic test_change_while_busy();
        int cyc; bit to;
        bus.score = 32'd16;
        repeat (10) @(negedge clk);
        bus.score = 32'd524288;
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL busychg_timeout1 got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h00000016) begin errors++; $display("FAIL busychg_first_bcd got %h exp 00000016", bus.bcd_cur); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busychg_idle_gap busy got %b exp 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busychg_restart busy got %b exp 1", bus.busy); end
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL busychg_timeout2 got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h00524288) begin errors++; $display("FAIL busychg_second_bcd got %h exp 00524288", bus.bcd_cur); end
        checks++; if (bus.new_best !== 1'b1) begin errors++; $display("FAIL busychg_new_best got %b exp 1", bus.new_best); end
        checks++; if (bus.best_score !== 32'd524288) begin errors++; $display("FAIL busychg_best_score got %0d exp 524288", bus.best_score); end
    endtask

    task automatic test_saturation_and_clear();
        int cyc; bit to;
        bus.score = 32'd100000000;
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL sat_timeout got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h99999999) begin errors++; $display("FAIL sat_bcd_cur got %h exp 99999999", bus.bcd_cur); end
        checks++; if (bus.best_score !== 32'd100000000) begin errors++; $display("FAIL sat_best_score got %0d exp 100000000", bus.best_score); end
        checks++; if (bus.bcd_best !== 32'h99999999) begin errors++; $display("FAIL sat_bcd_best got %h exp 99999999", bus.bcd_best); end
        checks++; if (bus.new_best !== 1'b1) begin errors++; $display("FAIL sat_new_best got %b exp 1", bus.new_best); end
        @(negedge clk);
        bus.score = 32'd5;
        repeat (33) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL clr_pre_done got busy=%b done=%b exp 1 0", bus.busy, bus.done); end
        bus.clear_best = 1'b1;
        @(negedge clk);
        bus.clear_best = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clr_done got %b exp 1", bus.done); end
        checks++; if (bus.bcd_cur !== 32'h00000005) begin errors++; $display("FAIL clr_bcd_cur got %h exp 00000005", bus.bcd_cur); end
        checks++; if (bus.best_score !== 32'd0) begin errors++; $display("FAIL clr_best_score got %0d exp 0", bus.best_score); end
        checks++; if (bus.bcd_best !== 32'h0) begin errors++; $display("FAIL clr_bcd_best got %h exp 00000000", bus.bcd_best); end
        checks++; if (bus.new_best !== 1'b0) begin errors++; $display("FAIL clr_new_best got %b exp 0", bus.new_best); end
    endtask

    task automatic test_reset_mid_conversion();
        int cyc; bit to; int pulses;
        @(negedge clk);
        bus.score = 32'd300;
        repeat (15) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.bcd_cur !== 32'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_async_clear got bcd_cur=%h busy=%b exp 00000000 0", bus.bcd_cur, bus.busy); end
        bus.score = 32'd64;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_stale_done got %0d pulses exp 0", pulses); end
        wait_done(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout got timeout exp done"); end
        checks++; if (bus.bcd_cur !== 32'h00000064) begin errors++; $display("FAIL midrst_bcd_cur got %h exp 00000064", bus.bcd_cur); end
        checks++; if (bus.best_score !== 32'd64 || bus.new_best !== 1'b1) begin errors++; $display("FAIL midrst_best got best=%0d new_best=%b exp 64 1", bus.best_score, bus.new_best); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.score = '0;
        bus.clear_best = 1'b0;
        test_reset();
        test_basic();
        test_lower_and_equal();
        test_change_while_busy();
        test_saturation_and_clear();
        test_reset_mid_conversion();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_tracker.md
Name: score_bcd_tracker

Overview:
- Sits directly downstream of the board score adder. It consumes the 32-bit binary game score and produces packed-BCD digits of the current score and the best score for the seven-segment/VGA score display.
- Conversion is sequential: a shift-add-3 (double-dabble) engine runs one bit per clock, so no wide combinational divider is needed.
- The block also holds the running best score and flags when a new best is set.

Parameters:
- W, 32, width of the binary score input.
- DIGITS, 8, number of BCD digits produced. Display range is 0 to 10^DIGITS-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- score  in  W  binary score from the score adder; combinational from the board register, may change on any cycle.
- clear_best  in  1  synchronous pulse; zeroes the best score.
- bcd_cur  out  4*DIGITS  packed BCD of the last converted score; digit 0 is in bits [3:0].
- bcd_best  out  4*DIGITS  packed BCD of the best score.
- best_score  out  W  binary best score.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse when bcd_cur, and possibly bcd_best, have just updated.
- new_best  out  1  one-cycle pulse, coincident with done, when this conversion raised the best score.

Behaviour:
- Reset, asynchronous on rst_n=0: all outputs are 0 and state is IDLE.
  - Internal registers are cleared: last_sampled=0, shift/BCD registers 0, bit counter 0.
  - Reset mid-conversion aborts the conversion immediately; no done pulse follows.
- States: IDLE, CONV, DONE.
- IDLE:
  - If score != last_sampled, latch score into the shift register and into last_sampled on edge E0.
  - Clear the BCD accumulator and set counter=0. Next state is CONV and busy=1 from E0.
  - If score == last_sampled, stay in IDLE.
- CONV: edges E1..EW each perform one double-dabble step.
  - First, every BCD digit >= 5 has 3 added.
  - Then {bcd, shift} shifts left by 1.
  - The counter increments each step. On the edge completing step W (EW), go to DONE.
- DONE, edge E(W+1):
  - Saturation: if the latched value > 10^DIGITS-1, bcd_cur is all 9s. Otherwise bcd_cur = accumulator.
  - Best compare uses best_score as it stands at this edge. If latched > best_score, then best_score <= latched, bcd_best <= the bcd_cur value being written, and new_best=1.
  - done=1 for the cycle following E(W+1). busy drops at E(W+1). Return to IDLE.
- Latency: W+1 edges from the sampling edge to the output update. For W=32, done is visible 33 edges after E0.
- Score changes while busy are ignored until the block returns to IDLE. The next IDLE cycle then compares against last_sampled and restarts if it differs. Intermediate values may be skipped; the final settled score is always converted.
- No back-to-back overlap: at least one IDLE cycle separates conversions.
- clear_best:
  - In any state, it sets best_score=0 and bcd_best=0 on the next edge.
  - If it coincides with the DONE edge, clear wins: best stays 0, new_best=0, and bcd_cur still updates.
  - A conversion in flight when clear_best occurs compares against the cleared best at DONE.
- Equal scores do not set new_best; the compare is strictly greater.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: release rst_n with score=0 -> block stays IDLE, busy=0, done never pulses, all outputs 0.
- Basic conversion: score=2048 held -> busy=1 for 33 cycles, then done and new_best pulse once. bcd_cur=0x00002048, bcd_best=0x00002048, best_score=2048.
- Lower score: then score=1024 -> bcd_cur=0x00001024, bcd_best remains 0x00002048, new_best=0. Repeating score=2048 -> new_best=0 (equal, not greater).
- Change while busy: score=16 then changes to 524288 ten cycles into the conversion -> first done gives 0x00000016. One IDLE cycle follows, then a second conversion gives bcd_cur=0x00524288 and new_best=1.
- Saturation and clear: score=100000000 -> bcd_cur=0x99999999, best_score=100000000. A clear_best asserted on the DONE edge of a later conversion of 5 -> bcd_cur=0x00000005, best_score=0, bcd_best=0, new_best=0.
- Reset mid-conversion: assert rst_n=0 at cycle 15 of a conversion -> outputs are 0 immediately (asynchronous), and no done pulse follows. After release with score=64 held, a fresh conversion yields 0x00000064.
